smix_scratchpad_ctrl: RTL and testbench

Sequencer for the scrypt SMIX (ROMix) loop. It owns the 128 KB scratchpad SRAM port and the BlockMix/Salsa core handshake. Phase 1 fills V[0..N-1] with successive BlockMix outputs. Phase 2 performs N data-dependent reads, XORs each read block into X, and remixes. It sits between the hash top-level FSM (start/done) and the scratchpad, and is the scratchpad's only master.

---
 rtl/smix_scratchpad_if.sv | 37 +++
 rtl/smix_scratchpad_ctrl.sv | 173 +++++++++++++++++
 tb/tb_smix_scratchpad_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smix_scratchpad_if.sv
// ============================================================================
// smix_scratchpad_if: host, scratchpad and BlockMix signals of the ROMix sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

interface smix_scratchpad_if;
  logic          start;
  logic [1023:0] x_in;
  logic          done;
  logic [1023:0] x_out;
  logic          busy;
  logic          sp_r_enable;
  logic          sp_w_enable;
  logic [16:0]   sp_addr;
  logic [1023:0] sp_w_data;
  logic [1023:0] sp_r_data;
  logic          bm_start;
  logic [1023:0] bm_in;
  logic          bm_done;
  logic [1023:0] bm_out;

  // The sequencer is the master: it drives the scratchpad and the core.
  modport master (
    input  start, x_in, sp_r_data, bm_done, bm_out,
    output done, x_out, busy, sp_r_enable, sp_w_enable, sp_addr, sp_w_data,
           bm_start, bm_in
  );

  modport slave (
    output start, x_in, sp_r_data, bm_done, bm_out,
    input  done, x_out, busy, sp_r_enable, sp_w_enable, sp_addr, sp_w_data,
           bm_start, bm_in
  );
endinterface

`default_nettype wire

// File: rtl/smix_scratchpad_ctrl.sv
// ============================================================================
// smix_scratchpad_ctrl: scrypt ROMix sequencer (V fill, data-dependent remix).
// Optional SMIX_ABORT_EN adds an abort input.  Rev 1.0
// ============================================================================
`default_nettype none

module smix_scratchpad_ctrl #(
  parameter int N_LOG2 = 10
) (
  input  logic               clk,
  input  logic               n_rst,
`ifdef SMIX_ABORT_EN
  input  logic               abort,
`endif
  smix_scratchpad_if.master  bus
);

  localparam logic [3:0] c_st_idle   = 4'd0;
  localparam logic [3:0] c_st_w_wr   = 4'd1;
  localparam logic [3:0] c_st_w_bm   = 4'd2;
  localparam logic [3:0] c_st_w_wait = 4'd3;
  localparam logic [3:0] c_st_r_adr  = 4'd4;
  localparam logic [3:0] c_st_r_cap  = 4'd5;
  localparam logic [3:0] c_st_r_bm   = 4'd6;
  localparam logic [3:0] c_st_r_wait = 4'd7;
  localparam logic [3:0] c_st_fin    = 4'd8;

  localparam logic [N_LOG2-1:0] c_last = '1;

  logic [3:0]        state_q,  state_d;
  logic [1023:0]     x_q,      x_d;
  logic [N_LOG2-1:0] i_q,      i_d;
  logic [N_LOG2-1:0] j_q,      j_d;
  logic [1023:0]     bm_in_q,  bm_in_d;
  logic [1023:0]     x_out_q,  x_out_d;

  logic              sp_r_en_w;
  logic              sp_w_en_w;
  logic              bm_start_w;
  logic              done_w;
  logic [N_LOG2-1:0] idx_w;
  logic [16:0]       sp_addr_w;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    i_d        = i_q;
    j_d        = j_q;
    bm_in_d    = bm_in_q;
    x_out_d    = x_out_q;
    sp_r_en_w  = 1'b0;
    sp_w_en_w  = 1'b0;
    bm_start_w = 1'b0;
    done_w     = 1'b0;
    idx_w      = '0;

    case (state_q)
      c_st_idle: begin
        if (bus.start) begin
          x_d     = bus.x_in;
          i_d     = '0;
          state_d = c_st_w_wr;
        end
      end
      c_st_w_wr: begin
        sp_w_en_w = 1'b1;
        idx_w     = i_q;
        bm_in_d   = x_q;
        state_d   = c_st_w_bm;
      end
      c_st_w_bm: begin
        bm_start_w = 1'b1;
        state_d    = c_st_w_wait;
      end
      c_st_w_wait: begin
        if (bus.bm_done) begin
          x_d = bus.bm_out;
          if (i_q == c_last) begin
            i_d     = '0;
            state_d = c_st_r_adr;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = c_st_w_wr;
          end
        end
      end
      c_st_r_adr: begin
        // Integerify: low index bits of byte 64 of X.
        sp_r_en_w = 1'b1;
        idx_w     = x_q[512 +: N_LOG2];
        j_d       = x_q[512 +: N_LOG2];
        state_d   = c_st_r_cap;
      end
      c_st_r_cap: begin
        // The read capture R is folded into the operand register: X^R is
        // formed as the SRAM data is sampled, so it is stable from R_BM on.
        sp_r_en_w = 1'b1;
        idx_w     = j_q;
        bm_in_d   = x_q ^ bus.sp_r_data;
        state_d   = c_st_r_bm;
      end
      c_st_r_bm: begin
        bm_start_w = 1'b1;
        state_d    = c_st_r_wait;
      end
      c_st_r_wait: begin
        if (bus.bm_done) begin
          x_d = bus.bm_out;
          if (i_q == c_last) begin
            // Loaded on entry to FIN so x_out is already valid alongside done.
            x_out_d = bus.bm_out;
            state_d = c_st_fin;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = c_st_r_adr;
          end
        end
      end
      c_st_fin: begin
        done_w  = 1'b1;
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

`ifdef SMIX_ABORT_EN
    if (abort && (state_q != c_st_idle)) begin
      state_d = c_st_idle;
      x_d     = x_q;
      i_d     = i_q;
      j_d     = j_q;
      bm_in_d = bm_in_q;
      x_out_d = x_out_q;
    end
`endif

    sp_addr_w              = '0;
    sp_addr_w[7 +: N_LOG2] = idx_w;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= c_st_idle;
      x_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      bm_in_q <= '0;
      x_out_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      i_q     <= i_d;
      j_q     <= j_d;
      bm_in_q <= bm_in_d;
      x_out_q <= x_out_d;
    end
  end

  assign bus.busy        = (state_q != c_st_idle);
  assign bus.done        = done_w;
  assign bus.x_out       = x_out_q;
  assign bus.sp_r_enable = sp_r_en_w;
  assign bus.sp_w_enable = sp_w_en_w;
  assign bus.sp_addr     = sp_addr_w;
  assign bus.sp_w_data   = x_q;
  assign bus.bm_start    = bm_start_w;
  assign bus.bm_in       = bm_in_q;

endmodule

`default_nettype wire

// File: tb/tb_smix_scratchpad_ctrl.sv
// ============================================================================
// tb_smix_scratchpad_ctrl: ROMix reference model, SRAM and BlockMix (in+1, L=3) models.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_smix_scratchpad_ctrl;
  localparam int N_LOG2 = 2;
  localparam int N      = 1 << N_LOG2;
  localparam int L      = 3;

  logic clk = 1'b0;
  logic n_rst;
`ifdef SMIX_ABORT_EN
  logic abort;
`endif

  smix_scratchpad_if bus ();

  smix_scratchpad_ctrl #(.N_LOG2(N_LOG2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
`ifdef SMIX_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int spur_rel  = 0;
  int bm_cnt    = 0;

  logic [1023:0] mem [N];
  logic [1023:0] rd_next;
  logic [1023:0] bm_op;
  logic [16:0]   exp_wr_addr [$];
  logic [1023:0] exp_wr_data [$];
  logic [16:0]   exp_rd_addr [$];
  logic [1023:0] exp_x;
  logic [1023:0] prev_exp_x;
  logic [16:0]   first_rd;
  logic chk_en       = 1'b0;
  logic run_active   = 1'b0;
  logic rd_half      = 1'b0;
  logic first_rd_set = 1'b0;
  logic phase2_seen  = 1'b0;
  logic prev_done    = 1'b0;
  logic abort_arm    = 1'b0;
  logic abort_fired  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[32*k +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (low 128b)", nm, act[127:0], exp[127:0]);
    end
  endtask

  // ROMix straight from the algorithm: fill V, then N indexed XOR-remixes.
  task automatic build_model(input logic [1023:0] xin);
    logic [1023:0] x;
    logic [1023:0] v [N];
    int j;
    exp_wr_addr.delete();
    exp_wr_data.delete();
    exp_rd_addr.delete();
    x = xin;
    for (int k = 0; k < N; k++) begin
      v[k] = x;
      exp_wr_addr.push_back(17'(k * 128));
      exp_wr_data.push_back(x);
      x = x + 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      j = int'(x[512 +: N_LOG2]);
      exp_rd_addr.push_back(17'(j * 128));
      x = (x ^ v[j]) + 1'b1;
    end
    exp_x = x;
  endtask

  // Compare process plus SRAM/BlockMix environment, all on the falling edge.
  always @(negedge clk) begin
    if (chk_en && n_rst) begin
      if (bus.sp_w_enable) begin
        chk("wr_rd_excl", 1024'(bus.sp_r_enable), 1024'(0));
        if (exp_wr_addr.size() == 0) chk("unexp_wr", 1024'(bus.sp_w_enable), 1024'(0));
        else begin
          chk("wr_addr", 1024'(bus.sp_addr), 1024'(exp_wr_addr.pop_front()));
          chk("wr_data", bus.sp_w_data, exp_wr_data.pop_front());
        end
      end
      if (bus.sp_r_enable) begin
        phase2_seen = 1'b1;
        chk("rd_in_p1", 1024'(exp_wr_addr.size()), 1024'(0));
        if (!first_rd_set) begin
          first_rd     = bus.sp_addr;
          first_rd_set = 1'b1;
        end
        if (exp_rd_addr.size() == 0) chk("unexp_rd", 1024'(bus.sp_r_enable), 1024'(0));
        else begin
          chk("rd_addr", 1024'(bus.sp_addr), 1024'(exp_rd_addr[0]));
          if (rd_half) exp_rd_addr.delete(0);
          rd_half = !rd_half;
        end
      end
      if (bus.done) begin
        if (!run_active) chk("unexp_done", 1024'(bus.done), 1024'(0));
        else begin
          chk("x_out", bus.x_out, exp_x);
          chk("latency", 1024'(cyc - start_cyc + 1), 1024'(46));
          run_active = 1'b0;
        end
      end
      if (prev_done) chk("busy_after_done", 1024'(bus.busy), 1024'(0));
      prev_done = bus.done;
    end

    if (bus.sp_w_enable) mem[bus.sp_addr[7 +: N_LOG2]] = bus.sp_w_data;
    bus.sp_r_data = rd_next;
    rd_next = bus.sp_r_enable ? mem[bus.sp_addr[7 +: N_LOG2]] : rnd1024();

`ifdef SMIX_ABORT_EN
    abort = 1'b0;
`endif
    bus.bm_done = 1'b0;
    if (!n_rst) bm_cnt = 0;
    else if (bm_cnt > 0) begin
      bm_cnt--;
      if (bm_cnt == 0) begin
        bus.bm_done = 1'b1;
        bus.bm_out  = bm_op + 1'b1;
`ifdef SMIX_ABORT_EN
        if (abort_arm && phase2_seen) begin
          abort       = 1'b1;
          abort_arm   = 1'b0;
          abort_fired = 1'b1;
        end
`endif
      end
    end
    if (bus.bm_start) begin
      bm_op  = bus.bm_in;
      bm_cnt = L;
    end
    if (spur_rel != 0 && cyc == start_cyc + spur_rel) begin
      bus.bm_done = 1'b1;
      bus.bm_out  = rnd1024();
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  1024'(bus.busy), 1024'(0));
    chk({tag, "_done"},  1024'(bus.done), 1024'(0));
    chk({tag, "_xout"},  bus.x_out, 1024'(0));
    chk({tag, "_wen"},   1024'(bus.sp_w_enable), 1024'(0));
    chk({tag, "_ren"},   1024'(bus.sp_r_enable), 1024'(0));
    chk({tag, "_addr"},  1024'(bus.sp_addr), 1024'(0));
    chk({tag, "_wdata"}, bus.sp_w_data, 1024'(0));
    chk({tag, "_bmst"},  1024'(bus.bm_start), 1024'(0));
    chk({tag, "_bmin"},  bus.bm_in, 1024'(0));
  endtask

  // Leaves start high for the current cycle; caller drops it.
  task automatic start_run(input logic [1023:0] xin);
    build_model(xin);
    @(negedge clk);
    bus.x_in     = xin;
    bus.start    = 1'b1;
    start_cyc    = cyc;
    run_active   = 1'b1;
    rd_half      = 1'b0;
    first_rd_set = 1'b0;
    phase2_seen  = 1'b0;
  endtask

  task automatic run_smix(input logic [1023:0] xin, input int inj_rel);
    start_run(xin);
    for (int k = 1; k <= 200 && run_active; k++) begin
      @(negedge clk);
      bus.start = (k == inj_rel);
      bus.x_in  = (k == inj_rel) ? ~xin : xin;
    end
    @(posedge clk);
    chk("done_timeout", 1024'(run_active), 1024'(0));
    run_active = 1'b0;
    chk("wr_left", 1024'(exp_wr_addr.size()), 1024'(0));
    chk("rd_left", 1024'(exp_rd_addr.size()), 1024'(0));
    prev_exp_x = exp_x;
    @(negedge clk);
  endtask

  logic [1023:0] x_b;

  initial begin
    n_rst     = 1'b0;
    bus.start = 1'b0;
    bus.x_in  = '0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    n_rst  = 1'b1;
    chk_en = 1'b1;

    // x_in = 0: writes 0..3, phase 2 always reads V[0]; X goes 4->5->6->7->8.
    run_smix('0, 0);
    chk("litA_model", exp_x, 1024'd8);
    chk("litA_xout", bus.x_out, 1024'd8);
    chk("litA_rd0", 1024'(first_rd), 1024'h000);

    // Bit 513 set: index 2 first, final X = x_in + 12.
    x_b = '0;
    x_b[513] = 1'b1;
    run_smix(x_b, 0);
    chk("litB_xout", bus.x_out, x_b + 1024'd12);
    chk("litB_rd0", 1024'(first_rd), 1024'h100);

    // start during W_WAIT (rel 4) and bm_done during W_WR (rel 6) are ignored.
    spur_rel = 6;
    run_smix({32{32'hA5C3_0F1E}}, 4);
    spur_rel = 0;

    // Reset deep in phase 2, held for three cycles.
    start_run({16{64'h0123_4567_89AB_CDEF}});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (27) @(negedge clk);
    chk_en = 1'b0;
    n_rst  = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("midrst");
    run_active = 1'b0;
    exp_wr_addr.delete();
    exp_wr_data.delete();
    exp_rd_addr.delete();
    prev_done = 1'b0;
    n_rst  = 1'b1;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    run_smix({8{128'hDEAD_BEEF_0000_0003_FFFF_FFFF_0000_0001}}, 0);

`ifdef SMIX_ABORT_EN
    // abort together with bm_done in R_WAIT.
    start_run(rnd1024());
    abort_fired = 1'b0;
    abort_arm   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 200 && !abort_fired; k++) @(posedge clk);
    chk("abort_fired", 1024'(abort_fired), 1024'(1));
    abort_arm  = 1'b0;
    run_active = 1'b0;
    exp_rd_addr.delete();
    exp_wr_addr.delete();
    exp_wr_data.delete();
    @(negedge clk);
    chk("abort_busy", 1024'(bus.busy), 1024'(0));
    chk("abort_done", 1024'(bus.done), 1024'(0));
    chk("abort_xout", bus.x_out, prev_exp_x);
    repeat (20) @(negedge clk);
    run_smix(rnd1024(), 0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
